// File: rtl/sysarr_loader_pkg.sv
// Shared types and default dimensions for the systolic-array input loader.
package sysarr_loader_pkg;

   localparam int SYSARR_N  = 4;
   localparam int SYSARR_DW = 16;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} loader_state_t;

   typedef logic [SYSARR_N*SYSARR_DW-1:0] row_t;

endpackage

// File: rtl/sysarr_skew_decode.sv
// Diagonal skew decoder: row r shifts while sh_cnt lies in [r, r+N-1].
module sysarr_skew_decode
   import sysarr_loader_pkg::*;
#(
   parameter int N  = SYSARR_N,
   parameter int CW = $clog2(2*SYSARR_N)
) (
   input  logic [CW-1:0] sh_cnt,
   input  logic          stall,
   input  logic          active,
   output logic [N-1:0]  fifo_shift
);

   always_comb begin
      fifo_shift = '0;
      for (int unsigned r = 0; r < unsigned'(N); r++) begin
         fifo_shift[r] = active && !stall
                         && (32'(sh_cnt) >= r)
                         && (32'(sh_cnt) <= r + unsigned'(N) - 1);
      end
   end

endmodule

// File: rtl/sysarr_input_loader.sv
// Loads an NxN tile into the row FIFOs, then issues diagonally skewed shift strobes.
// Optional perf counters are built when SYSARR_LOADER_PERF_EN is defined.
module sysarr_input_loader
   import sysarr_loader_pkg::*;
#(
   parameter int N  = SYSARR_N,
   parameter int DW = SYSARR_DW
) (
   input  logic            clk,
   input  logic            nRST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_row,
   input  logic            stall,
   output logic [N-1:0]    fifo_load,
   output logic [N*DW-1:0] fifo_load_values,
   output logic [N-1:0]    fifo_shift,
   output logic            busy,
   output logic            tile_done
`ifdef SYSARR_LOADER_PERF_EN
   ,
   output logic [31:0]     perf_stall_cycles,
   output logic [15:0]     perf_tiles
`endif
);

   localparam int            CW       = $clog2(2*N);
   localparam logic [CW-1:0] LAST_ROW = CW'(N-1);
   localparam logic [CW-1:0] LAST_SH  = CW'(2*N-2);

   loader_state_t state, state_nxt;
   logic [CW-1:0] row_cnt, row_cnt_nxt;
   logic [CW-1:0] sh_cnt, sh_cnt_nxt;
   logic [N-1:0]  load_nxt;
   logic          done_nxt;
   logic          take;

   assign in_ready = (state != SHIFT);
   assign busy     = (state != IDLE);
   assign take     = in_valid && in_ready;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state            <= IDLE;
         row_cnt          <= '0;
         sh_cnt           <= '0;
         fifo_load        <= '0;
         fifo_load_values <= '0;
         tile_done        <= 1'b0;
      end else begin
         state     <= state_nxt;
         row_cnt   <= row_cnt_nxt;
         sh_cnt    <= sh_cnt_nxt;
         fifo_load <= load_nxt;
         tile_done <= done_nxt;
         if (take) begin
            fifo_load_values <= in_row;
         end
      end
   end

   // IDLE and LOAD share the beat path: row_cnt is always 0 in IDLE.
   always_comb begin
      state_nxt   = state;
      row_cnt_nxt = row_cnt;
      sh_cnt_nxt  = sh_cnt;
      load_nxt    = '0;
      done_nxt    = 1'b0;
      case (state)
         IDLE, LOAD: begin
            if (take) begin
               load_nxt = N'(1) << row_cnt;
               if (row_cnt == LAST_ROW) begin
                  state_nxt   = SHIFT;
                  row_cnt_nxt = '0;
                  sh_cnt_nxt  = '0;
               end else begin
                  state_nxt   = LOAD;
                  row_cnt_nxt = row_cnt + 1'b1;
               end
            end
         end
         SHIFT: begin
            if (!stall) begin
               if (sh_cnt == LAST_SH) begin
                  state_nxt  = IDLE;
                  sh_cnt_nxt = '0;
                  done_nxt   = 1'b1;
               end else begin
                  sh_cnt_nxt = sh_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   sysarr_skew_decode #(
      .N  (N),
      .CW (CW)
   ) u_skew (
      .sh_cnt     (sh_cnt),
      .stall      (stall),
      .active     (state == SHIFT),
      .fifo_shift (fifo_shift)
   );

`ifdef SYSARR_LOADER_PERF_EN
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         perf_stall_cycles <= '0;
         perf_tiles        <= '0;
      end else begin
         if ((state == SHIFT) && stall && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 1'b1;
         end
         if (tile_done) begin
            perf_tiles <= perf_tiles + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sysarr_input_loader.sv
// Directed bench for sysarr_input_loader at N=4, DW=16.
module tb_sysarr_input_loader;
   import sysarr_loader_pkg::*;

   logic       tb_clk = 1'b0;
   logic       nRST;
   logic       in_valid;
   logic       in_ready;
   row_t       in_row;
   logic       stall;
   logic [3:0] fifo_load;
   row_t       fifo_load_values;
   logic [3:0] fifo_shift;
   logic       busy;
   logic       tile_done;
`ifdef SYSARR_LOADER_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [15:0] perf_tiles;
`endif

   int checks   = 0;
   int failures = 0;
   row_t rows [4];

   always #5 tb_clk = ~tb_clk;

   sysarr_input_loader #(
      .N  (4),
      .DW (16)
   ) dut (
      .clk              (tb_clk),
      .nRST             (nRST),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_row           (in_row),
      .stall            (stall),
      .fifo_load        (fifo_load),
      .fifo_load_values (fifo_load_values),
      .fifo_shift       (fifo_shift),
      .busy             (busy),
      .tile_done        (tile_done)
`ifdef SYSARR_LOADER_PERF_EN
      ,
      .perf_stall_cycles(perf_stall_cycles),
      .perf_tiles       (perf_tiles)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic load_tile(input int gap);
      for (int r = 0; r < 4; r++) begin
         if (r == 2) begin
            for (int g = 0; g < gap; g++) begin
               in_valid = 1'b0;
               tick();
               chk("gap_load", fifo_load, 4'b0000);
               chk("gap_values", fifo_load_values, rows[1]);
               chk("gap_ready", in_ready, 1'b1);
               chk("gap_busy", busy, 1'b1);
               chk("gap_shift", fifo_shift, 4'b0000);
            end
         end
         in_valid = 1'b1;
         in_row   = rows[r];
         #1;
         chk($sformatf("ready_row%0d", r), in_ready, 1'b1);
         tick();
         chk($sformatf("load_row%0d", r), fifo_load, 4'b0001 << r);
         chk($sformatf("values_row%0d", r), fifo_load_values, rows[r]);
      end
      in_valid = 1'b0;
   endtask

   // Expected strobe pattern per non-stalled SHIFT cycle.
   task automatic shift_phase(input int stall_at, input int stall_len);
      logic [3:0] pat [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      int cnt [4] = '{default: 0};
      int idx    = 0;
      int stalls = 0;
      int budget = 40;
      while (idx < 7 && budget > 0) begin
         stall = (idx == stall_at) && (stalls < stall_len);
         #1;
         chk($sformatf("shift_idx%0d_st%0d", idx, stall), fifo_shift, stall ? 4'b0000 : pat[idx]);
         chk("shift_ready", in_ready, 1'b0);
         chk("shift_done_early", tile_done, 1'b0);
         for (int r = 0; r < 4; r++) cnt[r] += int'(fifo_shift[r]);
         tick();
         if (stall) stalls++;
         else idx++;
         budget--;
      end
      stall = 1'b0;
      chk("shift_len", idx, 7);
      chk("stall_cycles", stalls, stall_len);
      chk("done_pulse", tile_done, 1'b1);
      chk("done_ready", in_ready, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_shift", fifo_shift, 4'b0000);
      for (int r = 0; r < 4; r++) chk($sformatf("row%0d_shifts", r), cnt[r], 4);
      tick();
      chk("done_clear", tile_done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rows[0] = 64'h0123456789ABCDEF;
      rows[1] = 64'h1111111111111111;
      rows[2] = 64'h2222222222222222;
      rows[3] = 64'h3333333333333333;
      nRST     = 1'b0;
      in_valid = 1'b0;
      in_row   = '0;
      stall    = 1'b0;
      repeat (2) tick();
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_shift", fifo_shift, 4'b0000);
      chk("rst_load", fifo_load, 4'b0000);
      chk("rst_values", fifo_load_values, 64'h0);
      chk("rst_done", tile_done, 1'b0);
      nRST = 1'b1;
      tick();
      chk("idle_busy", busy, 1'b0);

      load_tile(0);
      shift_phase(-1, 0);

      load_tile(0);
      shift_phase(3, 2);
`ifdef SYSARR_LOADER_PERF_EN
      chk("perf_stall", perf_stall_cycles, 32'd2);
      chk("perf_tiles", perf_tiles, 16'd2);
`endif

      load_tile(3);
      shift_phase(6, 1);

      load_tile(0);
      tick();
      tick();
      chk("pre_rst_shift", fifo_shift, 4'b0111);
      nRST = 1'b0;
      #1;
      chk("mid_rst_shift", fifo_shift, 4'b0000);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ready", in_ready, 1'b1);
      chk("mid_rst_load", fifo_load, 4'b0000);
      chk("mid_rst_values", fifo_load_values, 64'h0);
      chk("mid_rst_done", tile_done, 1'b0);
      tick();
      nRST = 1'b1;
      tick();
      load_tile(0);
      shift_phase(-1, 0);
`ifdef SYSARR_LOADER_PERF_EN
      chk("perf_stall_post_rst", perf_stall_cycles, 32'd0);
      chk("perf_tiles_post_rst", perf_tiles, 16'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
